// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg -- shared definitions for the CNN frame sequencer.
//   seq_state_e   : sequencer state encoding
//   CLEAR_CYCLES  : cycles cnn_reset is held high in CLEAR
//   frame_pixels  : pixels in an n x n frame
//   frame_results : CNN results produced for an n x n frame after pooling
package cnn_seq_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_CLEAR  = 3'd1,
        SEQ_STREAM = 3'd2,
        SEQ_DRAIN  = 3'd3,
        SEQ_DONE   = 3'd4,
        SEQ_ERROR  = 3'd5
    } seq_state_e;

    localparam int unsigned CLEAR_CYCLES = 2;

    function automatic int unsigned frame_pixels(input int unsigned n);
        return n * n;
    endfunction

    function automatic int unsigned frame_results(input int unsigned n, input int unsigned pool);
        return (n / pool) * (n / pool);
    endfunction

endpackage

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer -- streams one N x N frame of pixels into an external
// CNN pipeline and forwards its pooled results, counting them.
//
// Optional build macro: SEQ_TIMEOUT_EN -- enables the DRAIN idle timeout that
// moves the sequencer into ERROR. Without it DRAIN waits indefinitely and
// error is tied low.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   start               begin a frame (sampled in IDLE, DONE, ERROR)
//   busy, done, error   status: not IDLE / 1-cycle completion / sticky error
//   src_valid/data/ready  pixel source handshake (ready only in STREAM)
//   cnn_ce, cnn_activation, cnn_reset  drive to the CNN pipeline
//   cnn_valid, cnn_data, cnn_end       CNN result stream and end flag
//   res_valid, res_data, res_count     registered results and running count
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned N         = 480,
    parameter int unsigned POOL      = 2,
    parameter int unsigned PIX_WIDTH = 8,
    parameter int unsigned OUT_WIDTH = 20,
    parameter int unsigned TIMEOUT   = 4096,
    localparam int unsigned RES_TOTAL = frame_results(N, POOL),
    localparam int unsigned CNT_W     = $clog2(RES_TOTAL + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic                 src_valid,
    input  logic [PIX_WIDTH-1:0] src_data,
    output logic                 src_ready,
    output logic                 cnn_ce,
    output logic [PIX_WIDTH-1:0] cnn_activation,
    output logic                 cnn_reset,
    input  logic                 cnn_valid,
    input  logic [OUT_WIDTH-1:0] cnn_data,
    input  logic                 cnn_end,
    output logic                 res_valid,
    output logic [OUT_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]     res_count
);

    localparam int unsigned PIX_TOTAL = frame_pixels(N);
    localparam int unsigned PIX_W     = $clog2(PIX_TOTAL + 1);

    localparam logic [2:0] ST_IDLE   = SEQ_IDLE;
    localparam logic [2:0] ST_CLEAR  = SEQ_CLEAR;
    localparam logic [2:0] ST_STREAM = SEQ_STREAM;
    localparam logic [2:0] ST_DRAIN  = SEQ_DRAIN;
    localparam logic [2:0] ST_DONE   = SEQ_DONE;
    localparam logic [2:0] ST_ERROR  = SEQ_ERROR;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             clr_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic             xfer;
    logic             pix_last;
    logic             fwd_en;
    logic             res_full;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_expired;
    assign idle_expired = (idle_cnt == IDLE_W'(TIMEOUT - 1)) && !cnn_valid;
`endif

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign src_ready = (state == ST_STREAM);
    assign xfer      = src_valid && src_ready;
    assign pix_last  = (pix_cnt == PIX_W'(PIX_TOTAL - 1));
    assign fwd_en    = (state == ST_STREAM) || (state == ST_DRAIN);
    assign res_full  = (res_count == CNT_W'(RES_TOTAL));

`ifdef SEQ_TIMEOUT_EN
    assign error = (state == ST_ERROR);
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_CLEAR;
            // clr_cnt is 0 on the first CLEAR cycle and 1 on the second.
            ST_CLEAR:  if (clr_cnt) state_next = ST_STREAM;
            ST_STREAM: if (xfer && pix_last) state_next = ST_DRAIN;
            ST_DRAIN: begin
                // Completion wins over a timeout in the same cycle.
                if (res_full || cnn_end) state_next = ST_DONE;
`ifdef SEQ_TIMEOUT_EN
                else if (idle_expired) state_next = ST_ERROR;
`endif
            end
            ST_DONE:   state_next = start ? ST_CLEAR : ST_IDLE;
            ST_ERROR:  if (start) state_next = ST_CLEAR;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            clr_cnt        <= 1'b0;
            pix_cnt        <= '0;
            res_count      <= '0;
            cnn_ce         <= 1'b0;
            cnn_activation <= '0;
            cnn_reset      <= 1'b1;
            res_valid      <= 1'b0;
            res_data       <= '0;
        end else begin
            state     <= state_next;
            // Registered from the next state so cnn_reset is aligned exactly
            // with the CLEAR cycles and drops on the first clock after reset.
            cnn_reset <= (state_next == ST_CLEAR);
            clr_cnt   <= (state == ST_CLEAR) ? ~clr_cnt : 1'b0;
            cnn_ce    <= xfer;
            if (xfer) begin
                cnn_activation <= src_data;
                pix_cnt        <= pix_cnt + 1'b1;
            end
            res_valid <= fwd_en && cnn_valid;
            if (fwd_en && cnn_valid) begin
                res_data <= cnn_data;
                if (!res_full) res_count <= res_count + 1'b1;
            end
            if (state == ST_CLEAR) begin
                pix_cnt   <= '0;
                res_count <= '0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (state == ST_DRAIN && !cnn_valid) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer -- directed self-checking bench for
// cnn_frame_sequencer with N=4, POOL=2 (16 pixels, 4 results), TIMEOUT=8.
// The timeout scenario follows SEQ_TIMEOUT_EN; without it the bench checks
// that DRAIN waits with error low.
module tb_cnn_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, error;
    logic        src_valid;
    logic [7:0]  src_data;
    logic        src_ready;
    logic        cnn_ce;
    logic [7:0]  cnn_activation;
    logic        cnn_reset;
    logic        cnn_valid;
    logic [19:0] cnn_data;
    logic        cnn_end;
    logic        res_valid;
    logic [19:0] res_data;
    logic [2:0]  res_count;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process).
    bit         mon_en = 1'b0;
    bit         last_xfer = 1'b0;
    logic [7:0] last_data = '0;
    int         ce_total = 0;
    int         xfer_total = 0;
    int         resv_total = 0;
    int         done_total = 0;

    cnn_frame_sequencer #(
        .N(4), .POOL(2), .PIX_WIDTH(8), .OUT_WIDTH(20), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .cnn_ce(cnn_ce), .cnn_activation(cnn_activation), .cnn_reset(cnn_reset),
        .cnn_valid(cnn_valid), .cnn_data(cnn_data), .cnn_end(cnn_end),
        .res_valid(res_valid), .res_data(res_data), .res_count(res_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // cnn_ce must follow each accepted transfer by exactly one cycle,
    // carrying the accepted pixel.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                last_xfer = 1'b0;
            end else begin
                check("ce_latency", 32'(cnn_ce), 32'(last_xfer));
                if (cnn_ce && last_xfer)
                    check("activation", 32'(cnn_activation), 32'(last_data));
                ce_total   += int'(cnn_ce);
                resv_total += int'(res_valid);
                done_total += int'(done);
                if (src_valid && src_ready) xfer_total++;
                last_xfer = src_valid && src_ready;
                last_data = src_data;
            end
        end
    end

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        check("clr1_reset", 32'(cnn_reset), 32'd1);
        check("clr1_busy", 32'(busy), 32'd1);
        step();
        check("clr2_reset", 32'(cnn_reset), 32'd1);
        check("clr2_ready", 32'(src_ready), 32'd0);
        step();
        check("stream_reset", 32'(cnn_reset), 32'd0);
        check("stream_ready", 32'(src_ready), 32'd1);
        check("stream_cnt", 32'(res_count), 32'd0);
    endtask

    task automatic feed_pixels(input int count, input bit throttle);
        int acc = 0;
        int cyc = 0;
        bit ph = 1'b1;
        while (acc < count && cyc < 200) begin
            src_valid = throttle ? ph : 1'b1;
            src_data  = 8'(acc * 7 + 3);
            if (src_valid && src_ready) acc++;
            step();
            ph = ~ph;
            cyc++;
        end
        src_valid = 1'b0;
        check("pix_budget", 32'(acc), 32'(count));
    endtask

    task automatic feed_results(input int count, input bit end_on_last);
        for (int k = 0; k < count; k++) begin
            cnn_valid = 1'b1;
            cnn_data  = 20'(1000 + k);
            cnn_end   = end_on_last && (k == count - 1);
            step();
            check("res_valid", 32'(res_valid), 32'd1);
            check("res_data", 32'(res_data), 32'(1000 + k));
            check("res_count", 32'(res_count), 32'(k + 1));
        end
        cnn_valid = 1'b0;
        cnn_end   = 1'b0;
    endtask

    int base_ce, base_xfer, base_resv, base_done;

    task automatic snap();
        base_ce   = ce_total;
        base_xfer = xfer_total;
        base_resv = resv_total;
        base_done = done_total;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0;
        cnn_valid = 1'b0; cnn_data = '0; cnn_end = 1'b0;
        step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        check("rst_ce", 32'(cnn_ce), 32'd0);
        check("rst_resv", 32'(res_valid), 32'd0);
        check("rst_cnnrst", 32'(cnn_reset), 32'd1);
        check("rst_count", 32'(res_count), 32'd0);
        reset = 1'b1;
        step();
        check("rel_cnnrst", 32'(cnn_reset), 32'd0);
        mon_en = 1'b1;

        // Full frame, src_valid always high.
        snap();
        start_frame();
        feed_pixels(16, 1'b0);
        check("full_drain_ready", 32'(src_ready), 32'd0);
        feed_results(4, 1'b0);
        check("full_pre_done", 32'(done), 32'd0);
        step();
        check("full_done", 32'(done), 32'd1);
        step();
        check("full_idle", 32'(busy), 32'd0);
        check("full_done_off", 32'(done), 32'd0);
        check("full_ce16", 32'(ce_total - base_ce), 32'd16);
        check("full_resv4", 32'(resv_total - base_resv), 32'd4);
        check("full_done1", 32'(done_total - base_done), 32'd1);
        check("full_count", 32'(res_count), 32'd4);

        // cnn_valid in IDLE is not forwarded.
        cnn_valid = 1'b1; cnn_data = 20'd777;
        step();
        check("idle_ignore_v", 32'(res_valid), 32'd0);
        check("idle_ignore_c", 32'(res_count), 32'd4);

        // Throttled source; cnn_valid still high through CLEAR must be ignored.
        snap();
        start = 1'b1;
        step();
        start = 1'b0;
        check("thr_clr1_resv", 32'(res_valid), 32'd0);
        step();
        check("thr_clr2_resv", 32'(res_valid), 32'd0);
        cnn_valid = 1'b0;
        step();
        check("thr_stream_resv", 32'(res_valid), 32'd0);
        check("thr_stream_cnt", 32'(res_count), 32'd0);
        feed_pixels(16, 1'b1);
        check("thr_accepted", 32'(xfer_total - base_xfer), 32'd16);
        feed_results(4, 1'b0);
        step();
        check("thr_done", 32'(done), 32'd1);
        step();
        check("thr_ce16", 32'(ce_total - base_ce), 32'd16);

        // Early end with two results.
        start_frame();
        feed_pixels(16, 1'b0);
        feed_results(2, 1'b0);
        check("early_wait", 32'(done), 32'd0);
        cnn_end = 1'b1;
        step();
        cnn_end = 1'b0;
        check("early_done", 32'(done), 32'd1);
        check("early_count", 32'(res_count), 32'd2);
        step();
        check("early_idle", 32'(busy), 32'd0);

        // DRAIN with no results.
        start_frame();
        feed_pixels(16, 1'b0);
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step();
        check("to_before", 32'(error), 32'd0);
        step();
        check("to_error", 32'(error), 32'd1);
        check("to_busy", 32'(busy), 32'd1);
        step(); step(); step();
        check("to_sticky", 32'(error), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("to_clear_err", 32'(error), 32'd0);
        check("to_clr1_reset", 32'(cnn_reset), 32'd1);
        step();
        check("to_clr2_reset", 32'(cnn_reset), 32'd1);
        step();
        check("to_stream_reset", 32'(cnn_reset), 32'd0);
        feed_pixels(16, 1'b0);
        feed_results(4, 1'b1);
        check("to_end_done", 32'(done), 32'd1);
        step();
`else
        for (int i = 0; i < 20; i++) step();
        check("nto_error", 32'(error), 32'd0);
        check("nto_busy", 32'(busy), 32'd1);
        check("nto_done", 32'(done), 32'd0);
        feed_results(4, 1'b1);
        check("nto_end_done", 32'(done), 32'd1);
        step();
`endif
        check("coinc_count", 32'(res_count), 32'd4);

        // Mid-frame reset after 7 pixels.
        start_frame();
        feed_pixels(7, 1'b0);
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ready", 32'(src_ready), 32'd0);
        check("mid_ce", 32'(cnn_ce), 32'd0);
        check("mid_cnnrst", 32'(cnn_reset), 32'd1);
        check("mid_count", 32'(res_count), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("mid_rel_cnnrst", 32'(cnn_reset), 32'd0);
        mon_en = 1'b1;
        snap();
        start_frame();
        feed_pixels(16, 1'b0);
        check("mid_restart16", 32'(xfer_total - base_xfer), 32'd16);
        feed_results(4, 1'b0);
        step();
        check("mid_restart_done", 32'(done), 32'd1);
        step();

        // Back-to-back frames with start held through DONE.
        snap();
        start_frame();
        feed_pixels(16, 1'b0);
        feed_results(4, 1'b0);
        start = 1'b1;
        step();
        check("b2b_done", 32'(done), 32'd1);
        step();
        start = 1'b0;
        check("b2b_clear_busy", 32'(busy), 32'd1);
        check("b2b_clear_done", 32'(done), 32'd0);
        check("b2b_clear_rst", 32'(cnn_reset), 32'd1);
        step();
        check("b2b_clr2_rst", 32'(cnn_reset), 32'd1);
        step();
        check("b2b_stream", 32'(src_ready), 32'd1);
        check("b2b_cnt0", 32'(res_count), 32'd0);
        feed_pixels(16, 1'b0);
        feed_results(3, 1'b1);
        check("b2b2_done", 32'(done), 32'd1);
        check("b2b2_count", 32'(res_count), 32'd3);
        step();
        check("b2b_idle", 32'(busy), 32'd0);
        check("b2b_ce32", 32'(ce_total - base_ce), 32'd32);
        check("b2b_done2", 32'(done_total - base_done), 32'd2);
        check("b2b_resv7", 32'(resv_total - base_resv), 32'd7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
